icache_refill_unit: RTL

ICACHE_REFILL_UNIT -- requirements
Module: icache_refill_unit

---
 rtl/icache_refill_pkg.sv | 23 ++
 rtl/icache_refill_fifo.sv | 71 +++++++
 rtl/icache_refill_unit.sv | 137 +++++++++++++
 3 files changed

// File: rtl/icache_refill_pkg.sv
// Shared types and defaults for the instruction-cache refill unit:
// the 128-bit line type and the default-width tag/response entries.
package icache_refill_pkg;

  localparam int unsigned DEFAULT_DEPTH      = 4;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 16;
  localparam int unsigned DEFAULT_ID_WIDTH   = 4;
  localparam int unsigned WORDS_PER_LINE     = 4;

  typedef logic [WORDS_PER_LINE-1:0][31:0] line_t;

  typedef struct packed {
    logic [DEFAULT_ID_WIDTH-1:0]   id;
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
  } tag_entry_t;

  typedef struct packed {
    logic [DEFAULT_ID_WIDTH-1:0]   id;
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    line_t                         data;
  } resp_entry_t;

endpackage

// File: rtl/icache_refill_fifo.sv
// Synchronous FIFO with a registered head entry, so the head output is
// flop-driven and reads back as zero after reset or when drained.
module icache_refill_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  T     data_i,
  input  logic pop_i,
  output T     head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  T              head_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  // DEPTH is a power of two, so the pointers wrap naturally.
  assign rd_next = rd_ptr_q + 1'b1;
  assign head_o  = head_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_next;
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (!do_push && do_pop) begin
        count_q <= count_q - 1'b1;
      end
      // The next head is either the stored successor or the word being pushed.
      if (do_pop) begin
        if (count_q > CW'(1)) begin
          head_q <= mem_q[rd_next];
        end else if (do_push) begin
          head_q <= data_i;
        end else begin
          head_q <= '0;
        end
      end else if (empty_o && do_push) begin
        head_q <= data_i;
      end
    end
  end

endmodule

// File: rtl/icache_refill_unit.sv
// Turns cache misses into L2 line reads, tags each read in issue order and
// buffers returned lines until the cache accepts them, under a credit limit.
module icache_refill_unit
  import icache_refill_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned DEPTH      = DEFAULT_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req_i,
  output logic                  miss_gnt_o,
  input  logic [ADDR_WIDTH-1:0] miss_addr_i,
  input  logic [ID_WIDTH-1:0]   miss_id_i,
  output logic                  refill_valid_o,
  input  logic                  refill_ready_i,
  output logic [ID_WIDTH-1:0]   refill_id_o,
  output logic [ADDR_WIDTH-1:0] refill_addr_o,
  output line_t                 refill_data_o,
  output logic                  lint_req_o,
  input  logic                  lint_grant_i,
  output logic [ADDR_WIDTH-1:0] lint_addr_o,
  input  line_t                 lint_r_rdata_i,
  input  logic                  lint_r_valid_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
  } tag_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0]   id;
    logic [ADDR_WIDTH-1:0] addr;
    line_t                 data;
  } resp_t;

  logic [CW-1:0] inflight_q;
  logic [CW-1:0] inflight_d;
  logic          err_q;
  logic          err_d;
  logic          credit;
  logic          issue;
  logic          tag_pop;
  logic          tag_full;
  logic          tag_empty;
  logic          resp_full;
  logic          resp_empty;
  logic          refill_pop;
  tag_t          tag_in;
  tag_t          tag_head;
  resp_t         resp_in;
  resp_t         resp_head;

  // Credit counts lines issued but not yet handed to the cache, so the
  // response FIFO can never overflow; a same-cycle pop is deliberately not seen.
  assign credit     = (inflight_q < CW'(DEPTH));
  assign lint_req_o = !rst && miss_req_i && credit;
  assign lint_addr_o = miss_addr_i;
  assign miss_gnt_o = lint_req_o && lint_grant_i;
  assign issue      = miss_gnt_o;

  assign tag_pop        = lint_r_valid_i && !tag_empty;
  assign refill_valid_o = !resp_empty;
  assign refill_pop     = refill_valid_o && refill_ready_i;

  assign tag_in.id    = miss_id_i;
  assign tag_in.addr  = miss_addr_i;
  assign resp_in.id   = tag_head.id;
  assign resp_in.addr = tag_head.addr;
  assign resp_in.data = lint_r_rdata_i;

  icache_refill_fifo #(
    .DEPTH (DEPTH),
    .T     (tag_t)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (issue),
    .data_i  (tag_in),
    .pop_i   (tag_pop),
    .head_o  (tag_head),
    .full_o  (tag_full),
    .empty_o (tag_empty)
  );

  icache_refill_fifo #(
    .DEPTH (DEPTH),
    .T     (resp_t)
  ) u_resp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (tag_pop),
    .data_i  (resp_in),
    .pop_i   (refill_pop),
    .head_o  (resp_head),
    .full_o  (resp_full),
    .empty_o (resp_empty)
  );

  assign refill_id_o   = resp_head.id;
  assign refill_addr_o = resp_head.addr;
  assign refill_data_o = resp_head.data;

  always_comb begin
    inflight_d = inflight_q;
    if (issue && !refill_pop) begin
      inflight_d = inflight_q + 1'b1;
    end else if (!issue && refill_pop) begin
      inflight_d = inflight_q - 1'b1;
    end
    err_d = err_q || (lint_r_valid_i && tag_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      err_q      <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign busy_o = (inflight_q != '0);
  assign err_o  = err_q;

  // The credit limit makes pushing into a full queue impossible.
  assert property (@(posedge clk) disable iff (rst) !(issue && tag_full && !tag_pop));
  assert property (@(posedge clk) disable iff (rst) !(tag_pop && resp_full && !refill_pop));

endmodule
